// File: rtl/power_flow_stim_harness.sv
// Stimulus/capture harness for CGRA power-flow runs: sequences flush/config/run,
// drives per-lane Galois LFSR stimulus and counts/signs the output stream.
module power_flow_stim_harness #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NCH        = 1,
    parameter int unsigned FLUSH_CYC  = 1,
    parameter int unsigned CONFIG_CYC = 409,
    parameter int unsigned RUN_CYC    = 409,
    parameter logic [31:0] SEED       = 32'h1,
    parameter bit          HANDSHAKE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 flush,
    input  logic                 in_read_en,
    output logic [NCH*WIDTH-1:0] in_data,
    input  logic                 out_valid,
    input  logic [NCH*WIDTH-1:0] out_data,
    output logic                 toggle_win,
    output logic                 done,
    output logic [31:0]          out_count,
    output logic [31:0]          signature
);

    localparam logic [31:0] POLY   = 32'h80200003;
    localparam logic [31:0] GOLDEN = 32'h9E3779B9;
    localparam logic [31:0] F_LD   = 32'(FLUSH_CYC - 1);
    localparam logic [31:0] C_LD   = 32'(CONFIG_CYC - 1);
    localparam logic [31:0] R_LD   = 32'(RUN_CYC - 1);

    if (FLUSH_CYC == 0 || CONFIG_CYC == 0 || RUN_CYC == 0) begin : g_bad_len
        $error("power_flow_stim_harness: window lengths must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_CONFIG,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic        active;
    logic        adv;
    logic        begin_seq;
    logic [31:0] mix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Each window's counter is loaded with CYC-1 on entry; exit when it hits 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = F_LD;
                end
            end
            S_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = S_CONFIG;
                    cnt_nxt   = C_LD;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            S_CONFIG: begin
                if (cnt == '0) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = R_LD;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign flush      = (state == S_FLUSH);
    assign toggle_win = (state == S_RUN);
    assign done       = (state == S_DONE);

    assign active    = (state == S_FLUSH) || (state == S_CONFIG) || (state == S_RUN);
    assign adv       = active && (HANDSHAKE ? in_read_en : 1'b1);
    assign begin_seq = start && ((state == S_IDLE) || (state == S_DONE));

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        localparam logic [31:0] RAW   = SEED + 32'(i) * GOLDEN;
        localparam logic [31:0] LSEED = (RAW == 32'h0) ? 32'h1 : RAW;
        logic [31:0] lfsr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lfsr <= LSEED;
            end else if (adv) begin
                lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
            end
        end

        assign in_data[i*WIDTH +: WIDTH] = lfsr[WIDTH-1:0];
    end

    always_comb begin
        mix = '0;
        for (int i = 0; i < NCH; i++) begin
            mix = mix ^ 32'(out_data[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
            signature <= '0;
        end else if (begin_seq) begin
            out_count <= '0;
            signature <= '0;
        end else if (toggle_win && out_valid) begin
            if (out_count != 32'hFFFFFFFF) begin
                out_count <= out_count + 32'd1;
            end
            signature <= {signature[30:0], signature[31]} ^ mix;
        end
    end

endmodule

// File: tb/tb_power_flow_stim_harness.sv
// Directed bench for power_flow_stim_harness: window timing, LFSR stimulus,
// handshake gating, capture signature, async reset and multi-lane seeding.
module tb_power_flow_stim_harness;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT0: defaults
    logic        start0, rd0, ov0, f0, t0, d0;
    logic [15:0] od0, id0;
    logic [31:0] cnt0, sig0;

    // DUT1: handshake gated, short windows
    logic        start1, rd1, ov1, f1, t1, d1;
    logic [15:0] od1, id1;
    logic [31:0] cnt1, sig1;

    // DUT2: four 8-bit lanes, zero seed
    logic        start2, rd2, ov2, f2, t2, d2;
    logic [31:0] od2, id2;
    logic [31:0] cnt2, sig2;

    power_flow_stim_harness u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .flush(f0),
        .in_read_en(rd0), .in_data(id0), .out_valid(ov0),
        .out_data(od0), .toggle_win(t0), .done(d0),
        .out_count(cnt0), .signature(sig0)
    );

    power_flow_stim_harness #(
        .FLUSH_CYC(2), .CONFIG_CYC(3), .RUN_CYC(4),
        .SEED(32'h1234), .HANDSHAKE(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .flush(f1),
        .in_read_en(rd1), .in_data(id1), .out_valid(ov1),
        .out_data(od1), .toggle_win(t1), .done(d1),
        .out_count(cnt1), .signature(sig1)
    );

    power_flow_stim_harness #(
        .WIDTH(8), .NCH(4), .FLUSH_CYC(1), .CONFIG_CYC(2),
        .RUN_CYC(6), .SEED(32'h0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .flush(f2),
        .in_read_en(rd2), .in_data(id2), .out_valid(ov2),
        .out_data(od2), .toggle_win(t2), .done(d2),
        .out_count(cnt2), .signature(sig2)
    );

    typedef struct {
        int   k;
        logic fl;
        logic tg;
        logic dn;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [31:0] lf(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] s);
        return {s[30:0], s[31]};
    endfunction

    // Window index after k edges from the start edge: 0 idle, 1 flush, 2 config, 3 run, 4 done.
    function automatic int phase(input int k, input int f, input int c, input int r);
        if (k <= 0) return 0;
        if (k <= f) return 1;
        if (k <= f + c) return 2;
        if (k <= f + c + r) return 3;
        return 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] m0, ms0, m1, ms2, x2;
    logic [31:0] m2[4];
    int          nflush, ntog, first_tog, ph;

    initial begin
        tbl[0] = '{1,   1'b1, 1'b0, 1'b0};
        tbl[1] = '{2,   1'b0, 1'b0, 1'b0};
        tbl[2] = '{410, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{411, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{600, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{819, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{820, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{825, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        start0 = 0; rd0 = 0; ov0 = 0; od0 = 16'h00AA;
        start1 = 0; rd1 = 0; ov1 = 0; od1 = 16'h0;
        start2 = 0; rd2 = 0; ov2 = 0; od2 = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_flush", 32'(f0), 32'h0);
        chk("rst_toggle", 32'(t0), 32'h0);
        chk("rst_done", 32'(d0), 32'h0);
        chk("rst_count", cnt0, 32'h0);
        chk("rst_sig", sig0, 32'h0);
        chk("rst_seed0", 32'(id0), 32'h0001);
        chk("rst_seed1", 32'(id1), 32'h1234);
        chk("rst_seed2", id2, 32'h2B72B901);

        // Main sequence on DUT0; out_valid held high so CONFIG beats must be ignored
        m0 = 32'h1; ms0 = 32'h0;
        nflush = 0; ntog = 0; first_tog = -1;
        ov0 = 1'b1;
        start0 = 1'b1;
        for (int k = 1; k <= 825; k++) begin
            tick();
            start0 = 1'b0;
            ph = phase(k - 1, 1, 409, 409);
            if (ph >= 1 && ph <= 3) m0 = lf(m0);
            if (ph == 3) ms0 = rotl(ms0) ^ 32'h000000AA;
            chk("lane0_seq", 32'(id0), 32'(m0[15:0]));
            if (k == 2) chk("lane0_second", 32'(id0), 32'h0003);
            if (f0) nflush++;
            if (t0) begin
                ntog++;
                if (first_tog < 0) first_tog = k;
            end
            for (int j = 0; j < 8; j++) begin
                if (tbl[j].k == k) begin
                    chk("win_flush", 32'(f0), 32'(tbl[j].fl));
                    chk("win_toggle", 32'(t0), 32'(tbl[j].tg));
                    chk("win_done", 32'(d0), 32'(tbl[j].dn));
                end
            end
        end
        chk("flush_len", 32'(nflush), 32'd1);
        chk("toggle_len", 32'(ntog), 32'd409);
        chk("toggle_first", 32'(first_tog), 32'd411);
        chk("done_count", cnt0, 32'd409);
        chk("done_sig", sig0, ms0);

        // Restart from DONE: counters clear, LFSR continues
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("rs_done", 32'(d0), 32'h0);
        chk("rs_flush", 32'(f0), 32'h1);
        chk("rs_count", cnt0, 32'h0);
        chk("rs_sig", sig0, 32'h0);
        chk("rs_noreseed", 32'(id0), 32'(m0[15:0]));
        for (int k = 2; k <= 600; k++) begin
            tick();
            ph = phase(k - 1, 1, 409, 409);
            if (ph >= 1 && ph <= 3) m0 = lf(m0);
            chk("rs_lane0", 32'(id0), 32'(m0[15:0]));
        end
        chk("mid_toggle", 32'(t0), 32'h1);
        chk("mid_count_nz", 32'(cnt0 != 0), 32'h1);

        // Asynchronous reset mid-RUN
        #2;
        rst = 1'b1;
        #1;
        chk("arst_flush", 32'(f0), 32'h0);
        chk("arst_toggle", 32'(t0), 32'h0);
        chk("arst_done", 32'(d0), 32'h0);
        chk("arst_count", cnt0, 32'h0);
        chk("arst_sig", sig0, 32'h0);
        chk("arst_seed", 32'(id0), 32'h0001);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", 32'(t0), 32'h0);
        chk("post_rst_seed", 32'(id0), 32'h0001);
        ov0 = 1'b0;

        // Handshake gating on DUT1: idle must hold even with read enable
        rd1 = 1'b1;
        tick();
        tick();
        chk("hs_idle_hold", 32'(id1), 32'h1234);
        m1 = 32'h1234;
        start1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            rd1 = (k % 2) == 1;
            tick();
            start1 = 1'b0;
            ph = phase(k - 1, 2, 3, 4);
            if (ph >= 1 && ph <= 3 && (k % 2) == 1) m1 = lf(m1);
            chk("hs_lane", 32'(id1), 32'(m1[15:0]));
            chk("hs_flush", 32'(f1), 32'(phase(k, 2, 3, 4) == 1));
            chk("hs_toggle", 32'(t1), 32'(phase(k, 2, 3, 4) == 3));
        end
        rd1 = 1'b0;

        // Four lanes, zero seed, start pulse in RUN ignored
        m2[0] = 32'h1;
        m2[1] = 32'h9E3779B9;
        m2[2] = 32'h3C6EF372;
        m2[3] = 32'hDAA66D2B;
        ms2 = 32'h0;
        ov2 = 1'b1;
        start2 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            od2 = {8'(k), 8'(k * 3), 8'(k * 5), 8'(k * 7)};
            start2 = (k == 1) || (k == 5);
            x2 = 32'(od2[7:0] ^ od2[15:8] ^ od2[23:16] ^ od2[31:24]);
            tick();
            ph = phase(k - 1, 1, 2, 6);
            if (ph >= 1 && ph <= 3) begin
                for (int i = 0; i < 4; i++) m2[i] = lf(m2[i]);
            end
            if (ph == 3) ms2 = rotl(ms2) ^ x2;
            chk("nch_lanes", id2, {m2[3][7:0], m2[2][7:0], m2[1][7:0], m2[0][7:0]});
            chk("nch_toggle", 32'(t2), 32'(phase(k, 1, 2, 6) == 3));
            chk("nch_done", 32'(d2), 32'(phase(k, 1, 2, 6) == 4));
        end
        start2 = 1'b0;
        ov2 = 1'b0;
        chk("nch_count", cnt2, 32'd6);
        chk("nch_sig", sig2, ms2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
